image_crop_stream: RTL and testbench

//  Streaming crop stage directly upstream of the myproject_small input port (conv2d_1_input).

---
 rtl/crop_pkg.sv | 20 ++
 rtl/image_crop_stream_if.sv | 14 +
 rtl/axis_skid_fifo2.sv | 47 ++++
 rtl/image_crop_stream.sv | 110 +++++++++++
 tb/tb_image_crop_stream.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/crop_pkg.sv
// Shared types and default geometry for the streaming crop stage.
// Pure declarations: no latency, no flow control.
package crop_pkg;

    localparam int DEF_FP_TOTAL = 16;
    localparam int DEF_IN_ROWS  = 100;
    localparam int DEF_IN_COLS  = 160;
    localparam int DEF_OUT_ROWS = 48;
    localparam int DEF_OUT_COLS = 48;

    typedef logic [DEF_FP_TOTAL-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/image_crop_stream_if.sv
// AXI-stream style pixel bus: TDATA/TVALID forward, TREADY back.
// Wires only: no latency; the slave throttles the master through TREADY.
interface image_crop_stream_if
    import crop_pkg::*;
#(
    parameter int W = DEF_FP_TOTAL
);
    logic [W-1:0] TDATA;
    logic         TVALID;
    logic         TREADY;

    modport master (output TDATA, output TVALID, input TREADY);
    modport slave  (input TDATA, input TVALID, output TREADY);
endinterface

// File: rtl/axis_skid_fifo2.sv
// 2-entry registered valid/ready FIFO; output valid 1 cycle after push.
// in_rdy drops only when both entries hold data; push and pop may share a cycle.
module axis_skid_fifo2 #(
    parameter int W = 16
) (
    input  logic         ap_clk,
    input  logic         ap_rst_n,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);
    logic [W-1:0] mem0_q, mem1_q;
    logic         wr_ptr_q, rd_ptr_q;
    logic [1:0]   count_q;
    logic         push, pop;

    assign in_rdy  = (count_q != 2'd2);
    assign out_vld = (count_q != 2'd0);
    assign out_dat = rd_ptr_q ? mem1_q : mem0_q;
    assign push    = in_vld && in_rdy;
    assign pop     = out_vld && out_rdy;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            mem0_q   <= '0;
            mem1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                if (wr_ptr_q) mem1_q <= in_dat;
                else          mem0_q <= in_dat;
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/image_crop_stream.sv
// Streams one IN_ROWSxIN_COLS frame and forwards only the OUT_ROWSxOUT_COLS window at (crop_y, crop_x).
// Latency 1 cycle in->out; out-of-window beats always accepted, in-window beats stall when the FIFO is full.
module image_crop_stream
    import crop_pkg::*;
#(
    parameter int FP_TOTAL = DEF_FP_TOTAL,
    parameter int IN_ROWS  = DEF_IN_ROWS,
    parameter int IN_COLS  = DEF_IN_COLS,
    parameter int OUT_ROWS = DEF_OUT_ROWS,
    parameter int OUT_COLS = DEF_OUT_COLS
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    input  logic                       ap_start,
    output logic                       ap_done,
    output logic                       ap_idle,
    output logic                       ap_ready,
    input  logic [$clog2(IN_ROWS)-1:0] crop_y,
    input  logic [$clog2(IN_COLS)-1:0] crop_x,
    image_crop_stream_if.slave         img_in,
    image_crop_stream_if.master        crop_out
);
    localparam int RW    = $clog2(IN_ROWS);
    localparam int CW    = $clog2(IN_COLS);
    localparam int MAX_Y = IN_ROWS - OUT_ROWS;
    localparam int MAX_X = IN_COLS - OUT_COLS;

    state_t            state_q, state_d;
    logic [RW-1:0]     row_q, crop_y_q;
    logic [CW-1:0]     col_q, crop_x_q;
    logic [RW:0]       row_off;
    logic [CW:0]       col_off;
    logic              in_win, in_hs, last_beat;
    logic              fifo_in_rdy, fifo_out_vld, win_push_vld;
    logic [FP_TOTAL-1:0] fifo_out_dat;

    // Wider unsigned subtraction: rows/cols before the origin wrap to large values and fall outside.
    assign row_off   = {1'b0, row_q} - {1'b0, crop_y_q};
    assign col_off   = {1'b0, col_q} - {1'b0, crop_x_q};
    assign in_win    = (row_off < (RW+1)'(OUT_ROWS)) && (col_off < (CW+1)'(OUT_COLS));
    assign last_beat = (row_q == RW'(IN_ROWS-1)) && (col_q == CW'(IN_COLS-1));

    assign img_in.TREADY = (state_q == RUN) && (!in_win || fifo_in_rdy);
    assign in_hs         = img_in.TVALID && img_in.TREADY;
    assign win_push_vld  = (state_q == RUN) && img_in.TVALID && in_win;

    assign crop_out.TVALID = fifo_out_vld;
    assign crop_out.TDATA  = fifo_out_dat;

    axis_skid_fifo2 #(.W(FP_TOTAL)) u_fifo (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .in_vld   (win_push_vld),
        .in_rdy   (fifo_in_rdy),
        .in_dat   (img_in.TDATA),
        .out_vld  (fifo_out_vld),
        .out_rdy  (crop_out.TREADY),
        .out_dat  (fifo_out_dat)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            crop_y_q <= '0;
            crop_x_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                row_q <= '0;
                col_q <= '0;
                if (ap_start) begin
                    crop_y_q <= (crop_y > RW'(MAX_Y)) ? RW'(MAX_Y) : crop_y;
                    crop_x_q <= (crop_x > CW'(MAX_X)) ? CW'(MAX_X) : crop_x;
                end
            end else if (in_hs) begin
                if (col_q == CW'(IN_COLS-1)) begin
                    col_q <= '0;
                    row_q <= last_beat ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ap_idle  = 1'b0;
        ap_ready = 1'b0;
        ap_done  = 1'b0;
        case (state_q)
            IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    ap_ready = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN:     if (in_hs && last_beat) state_d = DRAIN;
            DRAIN:   if (!fifo_out_vld) state_d = DONE;
            DONE: begin
                ap_done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_image_crop_stream.sv
// Bench for image_crop_stream: a default-size instance plus a 10x16 -> 4x6 instance for multi-frame runs.
// Expected pixels come from the bench's own clamp and row-major window model.
module tb_image_crop_stream;
    import crop_pkg::*;

    typedef struct {
        int d;
        int cy;
        int cx;
        int stall;
        int pv;
        int pr;
        int nfr;
        int exp_first;
        int exp_last;
        int exp_cnt;
        int exp_stall_hs;
    } vec_t;

    logic        clk;
    logic        rst_n    [2];
    logic        ap_start [2];
    logic        ap_done  [2];
    logic        ap_idle  [2];
    logic        ap_ready [2];
    logic [7:0]  cy_in    [2];
    logic [7:0]  cx_in    [2];
    logic [15:0] in_dat   [2];
    logic        in_vld   [2];
    logic        in_rdy_o [2];
    logic [15:0] out_dat  [2];
    logic        out_vld  [2];
    logic        out_rdy  [2];

    int ir[2] = '{100, 10};
    int ic[2] = '{160, 16};
    int orw[2] = '{48, 4};
    int oc[2] = '{48, 6};

    int exp_cy[2], exp_cx[2], base[2];
    int out_cnt[2], err_cnt[2], hold_err[2], done_cnt[2], ready_cnt[2], in_hs[2];
    int first_v[2], last_v[2];
    bit prev_stall[2];
    logic [15:0] prev_dat[2];
    int hs_at_stall, timed_out;
    int tests, fails;
    int k, expv;

    image_crop_stream_if #(.W(16)) in_if0 ();
    image_crop_stream_if #(.W(16)) out_if0 ();
    image_crop_stream_if #(.W(16)) in_if1 ();
    image_crop_stream_if #(.W(16)) out_if1 ();

    assign in_if0.TDATA   = in_dat[0];
    assign in_if0.TVALID  = in_vld[0];
    assign in_rdy_o[0]    = in_if0.TREADY;
    assign out_dat[0]     = out_if0.TDATA;
    assign out_vld[0]     = out_if0.TVALID;
    assign out_if0.TREADY = out_rdy[0];
    assign in_if1.TDATA   = in_dat[1];
    assign in_if1.TVALID  = in_vld[1];
    assign in_rdy_o[1]    = in_if1.TREADY;
    assign out_dat[1]     = out_if1.TDATA;
    assign out_vld[1]     = out_if1.TVALID;
    assign out_if1.TREADY = out_rdy[1];

    image_crop_stream dut0 (
        .ap_clk   (clk),
        .ap_rst_n (rst_n[0]),
        .ap_start (ap_start[0]),
        .ap_done  (ap_done[0]),
        .ap_idle  (ap_idle[0]),
        .ap_ready (ap_ready[0]),
        .crop_y   (cy_in[0][6:0]),
        .crop_x   (cx_in[0]),
        .img_in   (in_if0),
        .crop_out (out_if0)
    );

    image_crop_stream #(.IN_ROWS(10), .IN_COLS(16), .OUT_ROWS(4), .OUT_COLS(6)) dut1 (
        .ap_clk   (clk),
        .ap_rst_n (rst_n[1]),
        .ap_start (ap_start[1]),
        .ap_done  (ap_done[1]),
        .ap_idle  (ap_idle[1]),
        .ap_ready (ap_ready[1]),
        .crop_y   (cy_in[1][3:0]),
        .crop_x   (cx_in[1][3:0]),
        .img_in   (in_if1),
        .crop_out (out_if1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Sample on the falling edge, half a cycle away from the DUT's active edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n[d]) begin
                prev_stall[d] = 1'b0;
            end else begin
                if (ap_done[d])  done_cnt[d]++;
                if (ap_ready[d]) ready_cnt[d]++;
                if (in_vld[d] && in_rdy_o[d]) in_hs[d]++;
                if (prev_stall[d] && (!out_vld[d] || out_dat[d] !== prev_dat[d])) hold_err[d]++;
                if (out_vld[d] && out_rdy[d]) begin
                    k    = out_cnt[d];
                    expv = base[d] + (exp_cy[d] + k / oc[d]) * ic[d] + exp_cx[d] + k % oc[d];
                    if (out_dat[d] !== expv[15:0]) err_cnt[d]++;
                    if (k == 0) first_v[d] = int'(out_dat[d]);
                    last_v[d] = int'(out_dat[d]);
                    out_cnt[d]++;
                end
                prev_stall[d] = out_vld[d] && !out_rdy[d];
                prev_dat[d]   = out_dat[d];
            end
        end
    end

    task automatic run_frame(input int d, input int cy, input int cx, input int b, input int stall,
                             input int pv, input int pr, input bit hold_start, input int drain_stall,
                             input int abort_after);
        int n, cyc, ds;
        n = ir[d] * ic[d];
        exp_cy[d] = (cy > ir[d] - orw[d]) ? ir[d] - orw[d] : cy;
        exp_cx[d] = (cx > ic[d] - oc[d]) ? ic[d] - oc[d] : cx;
        base[d] = b;
        out_cnt[d] = 0; err_cnt[d] = 0; hold_err[d] = 0; done_cnt[d] = 0;
        ready_cnt[d] = 0; in_hs[d] = 0; first_v[d] = -1; last_v[d] = -1;
        hs_at_stall = -1; timed_out = 0;
        @(posedge clk); #1;
        cy_in[d] = 8'(cy); cx_in[d] = 8'(cx);
        ap_start[d] = 1'b1; in_vld[d] = 1'b0; out_rdy[d] = 1'b0;
        cyc = 0; ds = 0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (!hold_start) ap_start[d] = 1'b0;
            if (cyc == stall) hs_at_stall = in_hs[d];
            if (done_cnt[d] != 0) break;
            if (abort_after > 0 && in_hs[d] >= abort_after) break;
            if (cyc > 40000) begin
                timed_out = 1;
                break;
            end
            if (in_hs[d] < n) begin
                in_vld[d] = ($urandom_range(99) < pv);
                in_dat[d] = 16'(b + in_hs[d]);
            end else begin
                in_vld[d] = 1'b0;
            end
            if (in_hs[d] == n && ds < drain_stall) begin
                out_rdy[d] = 1'b0;
                ds++;
                if (ds == drain_stall) begin
                    check("drain_not_idle", ap_idle[d], 0);
                    check("drain_out_vld", out_vld[d], 1);
                    ap_start[d] = 1'b0;
                end
            end else if (cyc <= stall) begin
                out_rdy[d] = 1'b0;
            end else begin
                out_rdy[d] = ($urandom_range(99) < pr);
            end
        end
        in_vld[d] = 1'b0;
        ap_start[d] = 1'b0;
        out_rdy[d] = 1'b0;
    endtask

    vec_t vec[5];

    initial begin
        tests = 0;
        fails = 0;
        vec[0] = '{0, 10, 10, 0, 100, 100, 1, 1610, 9177, 2304, -1};
        vec[1] = '{0, 10, 10, 5000, 100, 100, 1, 1610, 9177, 2304, 1612};
        vec[2] = '{0, 60, 130, 0, 100, 100, 1, 8432, 15999, 2304, -1};
        vec[3] = '{1, 3, 5, 0, 60, 60, 10, 53, 106, 24, -1};
        vec[4] = '{1, 9, 15, 0, 70, 50, 1, 106, 159, 24, -1};

        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; ap_start[d] = 1'b0; in_vld[d] = 1'b0; out_rdy[d] = 1'b0;
            in_dat[d] = '0; cy_in[d] = '0; cx_in[d] = '0;
            base[d] = 0; exp_cy[d] = 0; exp_cx[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_idle", ap_idle[0], 1);
        check("rst_done", ap_done[0], 0);
        check("rst_ready", ap_ready[0], 0);
        check("rst_in_tready", in_rdy_o[0], 0);
        check("rst_out_tvalid", out_vld[0], 0);
        check("rst_out_tdata", out_dat[0], 0);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        for (int t = 0; t < 5; t++) begin
            for (int f = 0; f < vec[t].nfr; f++) begin
                run_frame(vec[t].d, vec[t].cy, vec[t].cx, f * 256, vec[t].stall,
                          vec[t].pv, vec[t].pr, 1'b0, 0, 0);
                check($sformatf("v%0d_f%0d_timeout", t, f), timed_out, 0);
                check($sformatf("v%0d_f%0d_count", t, f), out_cnt[vec[t].d], vec[t].exp_cnt);
                check($sformatf("v%0d_f%0d_first", t, f), first_v[vec[t].d], vec[t].exp_first + f * 256);
                check($sformatf("v%0d_f%0d_last", t, f), last_v[vec[t].d], vec[t].exp_last + f * 256);
                check($sformatf("v%0d_f%0d_data_errs", t, f), err_cnt[vec[t].d], 0);
                check($sformatf("v%0d_f%0d_hold_errs", t, f), hold_err[vec[t].d], 0);
                check($sformatf("v%0d_f%0d_done", t, f), done_cnt[vec[t].d], 1);
                check($sformatf("v%0d_f%0d_ready", t, f), ready_cnt[vec[t].d], 1);
                check($sformatf("v%0d_f%0d_idle_after", t, f), ap_idle[vec[t].d], 1);
                if (vec[t].exp_stall_hs >= 0)
                    check($sformatf("v%0d_stall_beats", t), hs_at_stall, vec[t].exp_stall_hs);
            end
        end

        // Reset after 3000 input beats, then a fresh frame from origin (0,0).
        run_frame(0, 10, 10, 0, 0, 100, 100, 1'b0, 0, 3000);
        rst_n[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_done", done_cnt[0], 0);
        check("midrst_idle", ap_idle[0], 1);
        check("midrst_out_tvalid", out_vld[0], 0);
        check("midrst_in_tready", in_rdy_o[0], 0);
        rst_n[0] = 1'b1;
        run_frame(0, 0, 0, 0, 0, 100, 100, 1'b0, 0, 200);
        check("restart_first", first_v[0], 0);
        check("restart_done", done_cnt[0], 0);
        check("restart_data_errs", err_cnt[0], 0);
        check("restart_outputs", out_cnt[0] >= 48, 1);
        rst_n[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n[0] = 1'b1;

        // ap_start held high through RUN and a stretched DRAIN.
        run_frame(1, 9, 15, 0, 0, 100, 100, 1'b1, 6, 0);
        check("hold_start_timeout", timed_out, 0);
        check("hold_start_ready", ready_cnt[1], 1);
        check("hold_start_done", done_cnt[1], 1);
        check("hold_start_count", out_cnt[1], 24);
        check("hold_start_first", first_v[1], 106);
        check("hold_start_last", last_v[1], 159);
        check("hold_start_data_errs", err_cnt[1], 0);
        repeat (5) @(posedge clk);
        #1;
        check("hold_start_ready_after", ready_cnt[1], 1);
        check("hold_start_idle_after", ap_idle[1], 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
